signed_burst_accumulator: RTL

- Sequential accumulator placed directly downstream of the 4-bit two's-complement adder datapath.
- Accepts a burst of N signed 4-bit operands over a valid/ready handshake and sums them into a registered accumulator.
- Each step is selectable as wrap or saturate on overflow.
- Publishes the final sum with sticky overflow, negative and zero status, plus a one-cycle done pulse.

---
 rtl/signed_acc_pkg.sv | 18 +
 rtl/signed_burst_accumulator_add.sv | 29 ++
 rtl/signed_burst_accumulator.sv | 105 ++++++++++
 3 files changed

// File: rtl/signed_acc_pkg.sv
// Shared types and saturation limits for the signed burst accumulator.
package signed_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int SAT_MAX(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int SAT_MIN(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/signed_burst_accumulator_add.sv
// Two's-complement adder with signed overflow detect and optional clamp.
module signed_add_sat
    import signed_acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(SAT_MAX(WIDTH));
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(SAT_MIN(WIDTH));

    logic [WIDTH-1:0] raw;

    always_comb begin
        raw = a + b;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        result = raw;
        // Overflow direction follows the operand sign.
        if (sat && ovf) begin
            result = b[WIDTH-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/signed_burst_accumulator.sv
// Burst accumulator: sums N signed operands over valid/ready, wrap or saturate.
module signed_burst_accumulator
    import signed_acc_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 4
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               start_in,
    input  logic [COUNT_W-1:0] len_in,
    input  logic               sat_en_in,
    input  logic               op_valid_in,
    input  logic [WIDTH-1:0]   op_data_in,
    output logic               op_ready_out,
    output logic [WIDTH-1:0]   acc_out,
    output logic               busy_out,
    output logic               done_out,
    output logic               overflow_out,
    output logic               negative_out,
    output logic               zero_out
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               sat_q, sat_d;

    logic               xfer;
    logic [WIDTH-1:0]   sum;
    logic               step_ovf;

    signed_add_sat #(
        .WIDTH (WIDTH)
    ) u_add (
        .a      (acc_q),
        .b      (op_data_in),
        .sat    (sat_q),
        .result (sum),
        .ovf    (step_ovf)
    );

    assign xfer = op_valid_in && (state_q == RUN);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sat_d   = sat_q;
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = len_in;
                    sat_d   = sat_en_in;
                    state_d = (len_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    acc_d = sum;
                    ovf_d = ovf_q | step_ovf;
                    cnt_d = cnt_q - COUNT_W'(1);
                    if (cnt_q == COUNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sat_q   <= sat_d;
        end
    end

    assign op_ready_out = (state_q == RUN);
    assign busy_out     = (state_q != IDLE);
    assign done_out     = (state_q == DONE);
    assign acc_out      = acc_q;
    assign overflow_out = ovf_q;
    assign negative_out = acc_q[WIDTH-1];
    assign zero_out     = (acc_q == '0);

endmodule
